key_action_decoder: RTL and testbench

- Parametrised, registered successor to the combinational keyboard-to-action decoder.
- Samples the 6-slot USB HID keycode report on a report strobe and matches it against a run-time remappable keymap.
- Produces per-action held levels, one-cycle press/release pulses, long-hold flags and left/right conflict resolution.
- Sits between the USB keyboard interface and the game FSM / character controllers.

---
 rtl/key_pkg.sv | 53 +++++
 rtl/key_action_channel.sv | 69 ++++++
 rtl/key_action_decoder.sv | 119 +++++++++++
 tb/tb_key_action_decoder.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// Shared keycodes, action offsets, default keymap and auto-repeat timing for the
// key action decoder. Optional auto-repeat is built when KEY_AUTOREPEAT_EN is defined.
package key_pkg;

  localparam logic [7:0] KC_NONE     = 8'h00;
  localparam logic [7:0] KC_ROLLOVER = 8'h01;
  localparam logic [7:0] KC_A        = 8'h04;
  localparam logic [7:0] KC_D        = 8'h07;
  localparam logic [7:0] KC_W        = 8'h1A;
  localparam logic [7:0] KC_S        = 8'h16;
  localparam logic [7:0] KC_ARROW_L  = 8'h50;
  localparam logic [7:0] KC_ARROW_R  = 8'h4F;
  localparam logic [7:0] KC_ARROW_U  = 8'h52;
  localparam logic [7:0] KC_ARROW_D  = 8'h51;
  localparam logic [7:0] KC_SPACE    = 8'h2C;

  localparam int REPEAT_DELAY  = 15;
  localparam int REPEAT_PERIOD = 5;

  typedef enum logic [1:0] {
    ACT_LEFT    = 2'd0,
    ACT_RIGHT   = 2'd1,
    ACT_ATTACK  = 2'd2,
    ACT_DEFENSE = 2'd3
  } act_off_e;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_e;

  // START always sits on the last action index, whatever the player count.
  function automatic logic [7:0] default_code(input int idx, input int num_actions);
    if (idx == num_actions - 1) return KC_SPACE;
    case (idx)
      0:       return KC_A;
      1:       return KC_D;
      2:       return KC_W;
      3:       return KC_S;
      4:       return KC_ARROW_L;
      5:       return KC_ARROW_R;
      6:       return KC_ARROW_U;
      7:       return KC_ARROW_D;
      default: return KC_NONE;
    endcase
  endfunction

  function automatic logic repeat_due(input int count);
    if (count < REPEAT_DELAY) return 1'b0;
    return ((count - REPEAT_DELAY) % REPEAT_PERIOD) == 0;
  endfunction

endpackage

// File: rtl/key_action_channel.sv
// One action's held level, press/release pulses, saturating hold counter and
// long-hold flag; auto-repeat pulses are built only with KEY_AUTOREPEAT_EN.
module key_action_channel
  import key_pkg::*;
#(
  parameter int HOLD_W      = 8,
  parameter int HOLD_THRESH = 30
) (
  input  logic Clk,
  input  logic Reset_n,
  input  logic match,
  input  logic accept,
  output logic held,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_hold,
  output logic repeat_pulse
);

  localparam logic [HOLD_W-1:0] CNT_MAX  = '1;
  localparam logic [HOLD_W-1:0] THRESH_V = HOLD_W'(HOLD_THRESH);

  logic [HOLD_W-1:0] cnt;

  // The counter only advances on reports that see the key still down after a
  // previous report already registered it, so the press report itself counts 0.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      held          <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      cnt           <= '0;
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      if (accept) begin
        held          <= match;
        press_pulse   <= match & ~held;
        release_pulse <= ~match & held;
        if (!match) begin
          cnt <= '0;
        end else if (held && cnt != CNT_MAX) begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  assign long_hold = held && (cnt >= THRESH_V);

`ifdef KEY_AUTOREPEAT_EN
  logic rep_q;

  // A saturated counter no longer "reaches" new values, so repeats stop there.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rep_q <= 1'b0;
    end else begin
      rep_q <= accept && match && held && (cnt != CNT_MAX)
               && repeat_due(int'(cnt) + 1);
    end
  end

  assign repeat_pulse = rep_q;
`else
  assign repeat_pulse = 1'b0;
`endif

endmodule

// File: rtl/key_action_decoder.sv
// Registered HID-report to game-action decoder: remappable keymap, rollover
// filtering and left/right resolution. Auto-repeat via KEY_AUTOREPEAT_EN.
module key_action_decoder
  import key_pkg::*;
#(
  parameter int NUM_SLOTS   = 6,
  parameter int NUM_PLAYERS = 2,
  parameter int NUM_ACTIONS = 4 * NUM_PLAYERS + 1,
  parameter int LR_MODE     = 2,
  parameter int HOLD_W      = 8,
  parameter int HOLD_THRESH = 30
) (
  input  logic                           Clk,
  input  logic                           Reset_n,
  input  logic [8*NUM_SLOTS-1:0]         keycodes,
  input  logic                           kc_valid,
  input  logic                           map_we,
  input  logic [$clog2(NUM_ACTIONS)-1:0] map_idx,
  input  logic [7:0]                     map_code,
  output logic [NUM_ACTIONS-1:0]         act_held,
  output logic [NUM_ACTIONS-1:0]         act_press,
  output logic [NUM_ACTIONS-1:0]         act_release,
  output logic [NUM_ACTIONS-1:0]         act_long,
  output logic [NUM_ACTIONS-1:0]         act_repeat,
  output logic                           rollover_err
);

  localparam int OFF_L = int'(ACT_LEFT);
  localparam int OFF_R = int'(ACT_RIGHT);

  logic [7:0]             keymap [NUM_ACTIONS];
  logic [NUM_ACTIONS-1:0] raw;
  logic [NUM_ACTIONS-1:0] held_q;
  logic                   rollover;
  logic                   accept;
  dir_e                   last_dir [NUM_PLAYERS];

  // Matching reads the current keymap, so a same-cycle write affects only later reports.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < NUM_ACTIONS; i++) keymap[i] <= default_code(i, NUM_ACTIONS);
    end else if (map_we && int'(map_idx) < NUM_ACTIONS) begin
      keymap[map_idx] <= map_code;
    end
  end

  always_comb begin
    rollover = 1'b0;
    raw      = '0;
    for (int s = 0; s < NUM_SLOTS; s++) begin
      if (keycodes[8*s +: 8] == KC_ROLLOVER) rollover = 1'b1;
    end
    for (int i = 0; i < NUM_ACTIONS; i++) begin
      for (int s = 0; s < NUM_SLOTS; s++) begin
        if (keymap[i] != KC_NONE && keycodes[8*s +: 8] == keymap[i]) raw[i] = 1'b1;
      end
    end
  end

  assign accept = kc_valid & ~rollover;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rollover_err <= 1'b0;
    end else begin
      rollover_err <= kc_valid & rollover;
    end
  end

  for (genvar i = 0; i < NUM_ACTIONS; i++) begin : g_chan
    key_action_channel #(
      .HOLD_W      (HOLD_W),
      .HOLD_THRESH (HOLD_THRESH)
    ) u_chan (
      .Clk           (Clk),
      .Reset_n       (Reset_n),
      .match         (raw[i]),
      .accept        (accept),
      .held          (held_q[i]),
      .press_pulse   (act_press[i]),
      .release_pulse (act_release[i]),
      .long_hold     (act_long[i]),
      .repeat_pulse  (act_repeat[i])
    );
  end

  // Simultaneous left+right presses are ambiguous, so they leave last_dir alone.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int p = 0; p < NUM_PLAYERS; p++) last_dir[p] <= DIR_LEFT;
    end else if (accept) begin
      for (int p = 0; p < NUM_PLAYERS; p++) begin
        if (raw[4*p+OFF_L] && !held_q[4*p+OFF_L] &&
            !(raw[4*p+OFF_R] && !held_q[4*p+OFF_R])) begin
          last_dir[p] <= DIR_LEFT;
        end else if (raw[4*p+OFF_R] && !held_q[4*p+OFF_R] &&
                     !(raw[4*p+OFF_L] && !held_q[4*p+OFF_L])) begin
          last_dir[p] <= DIR_RIGHT;
        end
      end
    end
  end

  always_comb begin
    act_held = held_q;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      if (held_q[4*p+OFF_L] && held_q[4*p+OFF_R]) begin
        if (LR_MODE == 1) begin
          act_held[4*p+OFF_L] = 1'b0;
          act_held[4*p+OFF_R] = 1'b0;
        end else if (LR_MODE == 2) begin
          act_held[4*p+OFF_L] = (last_dir[p] == DIR_LEFT);
          act_held[4*p+OFF_R] = (last_dir[p] == DIR_RIGHT);
        end
      end
    end
  end

endmodule

// File: tb/tb_key_action_decoder.sv
// Self-checking bench for key_action_decoder: directed scenarios then random
// reports, all checked against a behavioural model. KEY_AUTOREPEAT_EN aware.
module tb_key_action_decoder;

  localparam int NA = 9;
  localparam int NS = 6;
  localparam int NP = 2;

  logic            clk;
  logic            rst_n;
  logic [8*NS-1:0] keycodes;
  logic            kc_valid;
  logic            map_we;
  logic [3:0]      map_idx;
  logic [7:0]      map_code;
  logic [NA-1:0]   act_held, act_press, act_release, act_long, act_repeat;
  logic            rollover_err;

  int model_map [NA];
  bit model_held [NA];
  int model_cnt [NA];
  bit model_right [NP];

  logic [NA-1:0] exp_held, exp_press, exp_rel, exp_long, exp_rep;
  logic          exp_roll;

  int n_checks;
  int n_errors;

  key_action_decoder dut (
    .Clk          (clk),
    .Reset_n      (rst_n),
    .keycodes     (keycodes),
    .kc_valid     (kc_valid),
    .map_we       (map_we),
    .map_idx      (map_idx),
    .map_code     (map_code),
    .act_held     (act_held),
    .act_press    (act_press),
    .act_release  (act_release),
    .act_long     (act_long),
    .act_repeat   (act_repeat),
    .rollover_err (rollover_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [47:0] rep(input logic [7:0] a = 8'h00, input logic [7:0] b = 8'h00,
                                      input logic [7:0] c = 8'h00);
    return {24'h0, c, b, a};
  endfunction

  task automatic compute_levels();
    for (int i = 0; i < NA; i++) begin
      exp_held[i] = model_held[i];
      exp_long[i] = model_held[i] && (model_cnt[i] >= 30);
    end
    for (int p = 0; p < NP; p++) begin
      if (model_held[4*p] && model_held[4*p+1]) begin
        exp_held[4*p]   = !model_right[p];
        exp_held[4*p+1] = model_right[p];
      end
    end
  endtask

  task automatic model_reset();
    int defaults [NA] = '{'h04, 'h07, 'h1A, 'h16, 'h50, 'h4F, 'h52, 'h51, 'h2C};
    for (int i = 0; i < NA; i++) begin
      model_map[i]  = defaults[i];
      model_held[i] = 1'b0;
      model_cnt[i]  = 0;
    end
    for (int p = 0; p < NP; p++) model_right[p] = 1'b0;
    exp_press = '0;
    exp_rel   = '0;
    exp_rep   = '0;
    exp_roll  = 1'b0;
    compute_levels();
  endtask

  task automatic model_update(input logic [47:0] codes, input bit we, input int idx,
                              input logic [7:0] code);
    bit roll;
    bit m [NA];
    bit pl, pr;
    roll = 1'b0;
    for (int s = 0; s < NS; s++) if (codes[8*s +: 8] == 8'h01) roll = 1'b1;
    exp_press = '0;
    exp_rel   = '0;
    exp_rep   = '0;
    exp_roll  = roll;
    if (!roll) begin
      for (int i = 0; i < NA; i++) begin
        m[i] = 1'b0;
        for (int s = 0; s < NS; s++)
          if (model_map[i] != 0 && int'(codes[8*s +: 8]) == model_map[i]) m[i] = 1'b1;
      end
      for (int p = 0; p < NP; p++) begin
        pl = m[4*p] && !model_held[4*p];
        pr = m[4*p+1] && !model_held[4*p+1];
        if (pl && !pr) model_right[p] = 1'b0;
        else if (pr && !pl) model_right[p] = 1'b1;
      end
      for (int i = 0; i < NA; i++) begin
        exp_press[i] = m[i] && !model_held[i];
        exp_rel[i]   = !m[i] && model_held[i];
        if (!m[i]) begin
          model_cnt[i] = 0;
        end else if (model_held[i] && model_cnt[i] < 255) begin
          model_cnt[i] = model_cnt[i] + 1;
`ifdef KEY_AUTOREPEAT_EN
          if (model_cnt[i] >= 15 && (model_cnt[i] - 15) % 5 == 0) exp_rep[i] = 1'b1;
`endif
        end
        model_held[i] = m[i];
      end
    end
    if (we && idx < NA) model_map[idx] = int'(code);
    compute_levels();
  endtask

  task automatic check_output(input string tag);
    n_checks++;
    assert (act_held === exp_held) else begin
      n_errors++;
      $error("[TB] FAIL %s act_held observed=%b expected=%b", tag, act_held, exp_held);
    end
    n_checks++;
    assert (act_press === exp_press) else begin
      n_errors++;
      $error("[TB] FAIL %s act_press observed=%b expected=%b", tag, act_press, exp_press);
    end
    n_checks++;
    assert (act_release === exp_rel) else begin
      n_errors++;
      $error("[TB] FAIL %s act_release observed=%b expected=%b", tag, act_release, exp_rel);
    end
    n_checks++;
    assert (act_long === exp_long) else begin
      n_errors++;
      $error("[TB] FAIL %s act_long observed=%b expected=%b", tag, act_long, exp_long);
    end
    n_checks++;
    assert (act_repeat === exp_rep) else begin
      n_errors++;
      $error("[TB] FAIL %s act_repeat observed=%b expected=%b", tag, act_repeat, exp_rep);
    end
    n_checks++;
    assert (rollover_err === exp_roll) else begin
      n_errors++;
      $error("[TB] FAIL %s rollover_err observed=%b expected=%b", tag, rollover_err, exp_roll);
    end
  endtask

  // One report (optionally with a same-cycle keymap write), then one idle cycle.
  task automatic apply_stimulus(input string tag, input logic [47:0] codes, input bit valid = 1'b1,
                                input bit we = 1'b0, input int idx = 0,
                                input logic [7:0] code = 8'h00);
    @(negedge clk);
    keycodes = codes;
    kc_valid = valid;
    map_we   = we;
    map_idx  = idx[3:0];
    map_code = code;
    if (valid) begin
      model_update(codes, we, idx, code);
    end else begin
      if (we && idx < NA) model_map[idx] = int'(code);
      exp_press = '0; exp_rel = '0; exp_rep = '0; exp_roll = 1'b0;
    end
    @(negedge clk);
    kc_valid = 1'b0;
    map_we   = 1'b0;
    keycodes = '0;
    check_output(tag);
    @(negedge clk);
    exp_press = '0; exp_rel = '0; exp_rep = '0; exp_roll = 1'b0;
    check_output({tag, "_idle"});
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_output(tag);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] pool [12] = '{8'h00, 8'h04, 8'h07, 8'h1A, 8'h16, 8'h50,
                              8'h4F, 8'h52, 8'h51, 8'h2C, 8'h28, 8'h33};
    logic [47:0] codes;
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b1;
    keycodes = '0;
    kc_valid = 1'b0;
    map_we   = 1'b0;
    map_idx  = '0;
    map_code = '0;
    model_reset();

    do_reset("reset");
    apply_stimulus("press_left", rep(8'h04));
    apply_stimulus("release_left", rep());

    apply_stimulus("hold_attack", rep(8'h1A));
    apply_stimulus("rollover", rep(8'h1A, 8'h01));
    apply_stimulus("after_rollover", rep(8'h1A));
    apply_stimulus("attack_off", rep());

    apply_stimulus("lr_left", rep(8'h04));
    apply_stimulus("lr_both", rep(8'h04, 8'h07));
    apply_stimulus("lr_right_up", rep(8'h04));
    apply_stimulus("lr_none", rep());
    do_reset("reset_lr");
    apply_stimulus("lr_both_same", rep(8'h04, 8'h07));
    apply_stimulus("lr_both_off", rep());

    apply_stimulus("remap_same_cycle", rep(8'h2C), 1'b1, 1'b1, 8, 8'h28);
    apply_stimulus("remap_old_key", rep(8'h2C));
    apply_stimulus("remap_new_key", rep(8'h28));
    apply_stimulus("remap_restore", rep(), 1'b1, 1'b1, 8, 8'h2C);
    apply_stimulus("write_oob", rep(), 1'b0, 1'b1, 12, 8'h04);
    apply_stimulus("after_oob", rep(8'h04));
    apply_stimulus("disable_map", rep(), 1'b1, 1'b1, 0, 8'h00);
    apply_stimulus("disabled_key", rep(8'h00, 8'h04));
    apply_stimulus("restore_map", rep(), 1'b0, 1'b1, 0, 8'h04);

    for (int k = 0; k < 300; k++) apply_stimulus("long_hold", rep(8'h52));
    apply_stimulus("long_release", rep());

    for (int k = 0; k < 30; k++) apply_stimulus("repeat_hold", rep(8'h16));
    apply_stimulus("repeat_release", rep());

    apply_stimulus("mid_hold", rep(8'h04, 8'h2C));
    do_reset("reset_mid_hold");
    apply_stimulus("post_reset_idle", rep(), 1'b0);

    for (int k = 0; k < 400; k++) begin
      codes = '0;
      for (int s = 0; s < NS; s++)
        if ($urandom_range(0, 2) == 0) codes[8*s +: 8] = pool[$urandom_range(0, 11)];
      if ($urandom_range(0, 19) == 0) codes[8*$urandom_range(0, NS-1) +: 8] = 8'h01;
      if ($urandom_range(0, 9) == 0)
        apply_stimulus("random_remap", codes, $urandom_range(0, 3) != 0, 1'b1,
                       $urandom_range(0, 15), pool[$urandom_range(0, 11)]);
      else
        apply_stimulus("random", codes, $urandom_range(0, 5) != 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
